// File: rtl/hazard_ctrl_mdu.sv
// Decode-stage hazard controller for the pipelined MIPS core.
// Tracks in-flight GPR writes in a small scoreboard shifted once per cycle
// and compares their remaining latency (Tnew) against the D-stage operand
// read deadline (Tuse). It produces stall, bubble and D-stage forward
// selects. A busy counter for the multiply/divide unit holds back HI/LO
// users while an operation is in progress.
module hazard_ctrl_mdu #(
  parameter int NSTG        = 3,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int FW          = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_d,
  input  logic [4:0]    rs_d,
  input  logic [4:0]    rt_d,
  input  logic [TW-1:0] tuse_rs_d,
  input  logic [TW-1:0] tuse_rt_d,
  input  logic [4:0]    dst_d,
  input  logic [TW-1:0] tnew_d,
  input  logic          md_use_d,
  input  logic          md_start_d,
  input  logic          md_div_d,
  output logic          stall,
  output logic          bubble_e,
  output logic [FW-1:0] fwd_rs_d,
  output logic [FW-1:0] fwd_rt_d,
  output logic          md_busy
);

  localparam int            CW        = $clog2(DIV_CYCLES + 1);
  localparam logic [TW-1:0] TUSE_NONE = {TW{1'b1}};

  // Scoreboard: slot 1 is the E stage, higher slots are older instructions.
  logic          v_r    [1:NSTG];
  logic [4:0]    addr_r [1:NSTG];
  logic [TW-1:0] tnew_r [1:NSTG];
  logic [CW-1:0] cnt_r;

  logic          take_rs_s, take_rt_s;
  logic          hit_rs_s, hit_rt_s;
  logic [FW-1:0] sel_rs_s, sel_rt_s;
  logic [TW-1:0] tn_rs_s, tn_rt_s;
  logic          data_stall_s, md_stall_s, busy_s, stall_s;
  logic [FW-1:0] fwd_rs_s, fwd_rt_s;

  // Find the nearest (youngest) scoreboard slot writing each D operand.
  always_comb begin
    hit_rs_s  = 1'b0;
    hit_rt_s  = 1'b0;
    sel_rs_s  = {FW{1'b0}};
    sel_rt_s  = {FW{1'b0}};
    tn_rs_s   = {TW{1'b0}};
    tn_rt_s   = {TW{1'b0}};
    take_rs_s = 1'b0;
    take_rt_s = 1'b0;
    for (int k = 1; k <= NSTG; k++) begin
      take_rs_s = !hit_rs_s && v_r[k] && (addr_r[k] == rs_d) &&
                  (rs_d != 5'd0) && (tuse_rs_d != TUSE_NONE);
      take_rt_s = !hit_rt_s && v_r[k] && (addr_r[k] == rt_d) &&
                  (rt_d != 5'd0) && (tuse_rt_d != TUSE_NONE);
      sel_rs_s  = take_rs_s ? FW'(k) : sel_rs_s;
      sel_rt_s  = take_rt_s ? FW'(k) : sel_rt_s;
      tn_rs_s   = take_rs_s ? tnew_r[k] : tn_rs_s;
      tn_rt_s   = take_rt_s ? tnew_r[k] : tn_rt_s;
      hit_rs_s  = hit_rs_s | take_rs_s;
      hit_rt_s  = hit_rt_s | take_rt_s;
    end
  end

  // Stall and forward decisions; all outputs are held quiet during reset.
  always_comb begin
    busy_s       = (cnt_r != {CW{1'b0}});
    data_stall_s = valid_d && ((hit_rs_s && (tn_rs_s > tuse_rs_d)) ||
                               (hit_rt_s && (tn_rt_s > tuse_rt_d)));
    md_stall_s   = valid_d && md_use_d && busy_s;
    stall_s      = !reset && (data_stall_s || md_stall_s);
    fwd_rs_s     = {FW{1'b0}};
    fwd_rt_s     = {FW{1'b0}};
    if (!reset && hit_rs_s && (tn_rs_s == {TW{1'b0}})) begin
      fwd_rs_s = sel_rs_s;
    end else begin
      fwd_rs_s = {FW{1'b0}};
    end
    if (!reset && hit_rt_s && (tn_rt_s == {TW{1'b0}})) begin
      fwd_rt_s = sel_rt_s;
    end else begin
      fwd_rt_s = {FW{1'b0}};
    end
  end

  assign stall    = stall_s;
  assign bubble_e = stall_s;
  assign fwd_rs_d = fwd_rs_s;
  assign fwd_rt_d = fwd_rt_s;
  assign md_busy  = !reset && busy_s;

  // Scoreboard shift: new entry (or bubble) into slot 1, others age by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= NSTG; k++) begin
        v_r[k]    <= 1'b0;
        addr_r[k] <= 5'd0;
        tnew_r[k] <= {TW{1'b0}};
      end
    end else begin
      if (stall_s) begin
        v_r[1]    <= 1'b0;
        addr_r[1] <= 5'd0;
        tnew_r[1] <= {TW{1'b0}};
      end else begin
        v_r[1]    <= valid_d && (dst_d != 5'd0);
        addr_r[1] <= dst_d;
        tnew_r[1] <= tnew_d;
      end
      for (int k = 2; k <= NSTG; k++) begin
        v_r[k]    <= v_r[k-1];
        addr_r[k] <= addr_r[k-1];
        tnew_r[k] <= (tnew_r[k-1] == {TW{1'b0}}) ? {TW{1'b0}} : (tnew_r[k-1] - TW'(1));
      end
    end
  end

  // MDU busy counter: load on an accepted mult/div, then count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (md_start_d && valid_d && !stall_s) begin
      cnt_r <= md_div_d ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Self-checking bench for hazard_ctrl_mdu: a driver issues instructions and
// pushes the reference model's expected outputs into a queue; a monitor
// pops and compares on the falling edge.
module tb_hazard_ctrl_mdu;

  localparam int NSTG  = 3;
  localparam int MULTC = 5;
  localparam int DIVC  = 10;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tur;
    logic [1:0] tut;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       mu;
    logic       ms;
    logic       md;
  } ins_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_d, md_use_d, md_start_d, md_div_d;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       stall, bubble_e, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d;

  hazard_ctrl_mdu dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .dst_d(dst_d), .tnew_d(tnew_d),
    .md_use_d(md_use_d), .md_start_d(md_start_d), .md_div_d(md_div_d),
    .stall(stall), .bubble_e(bubble_e), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  // Reference model: what entered E in each of the last NSTG cycles,
  // with the Tnew it carried at E entry; remaining latency is derived from age.
  logic       hv [1:NSTG];
  logic [4:0] hd [1:NSTG];
  int         ht [1:NSTG];
  int         cyc = 0;
  int         busy_until = 0;
  ins_t       cur;
  logic       cur_rst = 1'b1;
  logic       cur_stall = 1'b0;

  function automatic void eval_op(input logic [4:0] x, input logic [1:0] tu,
                                  output logic st, output int fw);
    logic found;
    int rem;
    found = 1'b0;
    st = 1'b0;
    fw = 0;
    for (int k = 1; k <= NSTG; k++) begin
      if (!found && hv[k] && hd[k] == x && x != 5'd0 && tu != 2'd3) begin
        found = 1'b1;
        rem = ht[k] - (k - 1);
        if (rem < 0) rem = 0;
        st = (rem > int'(tu));
        fw = (rem == 0) ? k : 0;
      end
    end
  endfunction

  // Drive one cycle: commit the previous cycle to the model, apply new inputs,
  // predict this cycle's outputs and queue them.
  task automatic drive1(input logic r, input ins_t i);
    logic s1, s2, es, mb;
    int f1, f2;
    @(posedge clk);
    if (cur_rst) begin
      for (int k = 1; k <= NSTG; k++) begin
        hv[k] = 1'b0; hd[k] = 5'd0; ht[k] = 0;
      end
      busy_until = 0;
    end else begin
      for (int k = NSTG; k >= 2; k--) begin
        hv[k] = hv[k-1]; hd[k] = hd[k-1]; ht[k] = ht[k-1];
      end
      hv[1] = !cur_stall && cur.v && cur.dst != 5'd0;
      hd[1] = cur.dst;
      ht[1] = int'(cur.tnew);
      if (cur.v && cur.ms && !cur_stall)
        busy_until = cyc + 1 + (cur.md ? DIVC : MULTC);
    end
    cyc++;
    #1;
    reset = r; valid_d = i.v; rs_d = i.rs; rt_d = i.rt;
    tuse_rs_d = i.tur; tuse_rt_d = i.tut; dst_d = i.dst; tnew_d = i.tnew;
    md_use_d = i.mu; md_start_d = i.ms; md_div_d = i.md;
    cur = i;
    cur_rst = r;
    es = 1'b0; mb = 1'b0; f1 = 0; f2 = 0;
    if (!r) begin
      eval_op(i.rs, i.tur, s1, f1);
      eval_op(i.rt, i.tut, s2, f2);
      mb = (cyc < busy_until);
      es = i.v && (s1 || s2 || (i.mu && mb));
    end
    cur_stall = es;
    exp_q.push_back({es, es, 2'(f1), 2'(f2), mb});
  endtask

  // Repeat an instruction in D until the model says it leaves D.
  task automatic issue(input ins_t i);
    int n;
    n = 0;
    drive1(1'b0, i);
    while (cur_stall && n < 20) begin
      drive1(1'b0, i);
      n++;
    end
    if (cur_stall) begin
      checks++; errors++;
      $display("FAIL issue_bound: instruction still stalled after %0d cycles, required release", n);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] rs, input logic [1:0] tur,
                              input logic [4:0] rt, input logic [1:0] tut,
                              input logic [4:0] dst, input logic [1:0] tnew,
                              input logic mu, input logic ms, input logic md);
    ins_t i;
    i = '{v: 1'b1, rs: rs, rt: rt, tur: tur, tut: tut, dst: dst, tnew: tnew,
          mu: mu, ms: ms, md: md};
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i.v    = ($urandom_range(0, 9) != 0);
    i.rs   = 5'($urandom_range(0, 3));
    i.rt   = 5'($urandom_range(0, 3));
    i.tur  = 2'($urandom_range(0, 3));
    i.tut  = 2'($urandom_range(0, 3));
    i.dst  = 5'($urandom_range(0, 3));
    i.tnew = 2'($urandom_range(0, 2));
    i.mu   = ($urandom_range(0, 4) == 0);
    i.ms   = i.mu && ($urandom_range(0, 1) == 1);
    i.md   = ($urandom_range(0, 1) == 1);
    return i;
  endfunction

  // Monitor: compare every presented cycle against the queued prediction.
  always @(negedge clk) begin
    logic [6:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({stall, bubble_e, fwd_rs_d, fwd_rt_d, md_busy} !== e) begin
        errors++;
        $display("FAIL cycle%0d: got stall=%b bubble=%b fwd_rs=%0d fwd_rt=%0d busy=%b, required stall=%b bubble=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                 cyc, stall, bubble_e, fwd_rs_d, fwd_rt_d, md_busy,
                 e[6], e[5], e[4:3], e[2:1], e[0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nop, lw1, addu1, beq12, ori3, indep, addu3, wr0, rd0, mlt, dvv, mflo, ri;
    nop   = '0; nop.tur = 2'd3; nop.tut = 2'd3;
    lw1   = mk(5'd0, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    addu1 = mk(5'd1, 2'd1, 5'd2, 2'd1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
    beq12 = mk(5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    ori3  = mk(5'd0, 2'd1, 5'd0, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    indep = mk(5'd7, 2'd1, 5'd8, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    addu3 = mk(5'd2, 2'd1, 5'd3, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
    wr0   = mk(5'd0, 2'd1, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    rd0   = mk(5'd0, 2'd0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
    mlt   = mk(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    dvv   = mk(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    mflo  = mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b1, 1'b0, 1'b0);
    cur = nop;

    repeat (3) drive1(1'b1, nop);

    // lw then dependent ALU op; then nops to observe forwarding
    issue(lw1); issue(addu1); repeat (3) issue(nop);
    // lw then branch (Tuse 0)
    issue(lw1); issue(beq12); repeat (3) issue(nop);
    // ALU result forwarded after one independent instruction
    issue(ori3); issue(indep); issue(addu3); repeat (3) issue(nop);
    // writes to $0 are invisible
    issue(wr0); issue(rd0); issue(rd0); repeat (3) issue(nop);
    // mult / div followed by mflo
    issue(mlt); issue(mflo); repeat (2) issue(nop);
    issue(dvv); issue(mflo); repeat (2) issue(nop);
    // reset in the middle of a divide with mflo waiting
    issue(dvv);
    repeat (3) drive1(1'b0, mflo);
    drive1(1'b1, mflo);
    drive1(1'b0, mflo);
    repeat (3) issue(nop);

    // randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        drive1(1'b1, rnd_ins());
      end else if (cur_stall && $urandom_range(0, 9) < 7) begin
        drive1(1'b0, cur);
      end else begin
        ri = rnd_ins();
        drive1(1'b0, ri);
      end
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d predictions left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
